// File: rtl/mult_acc_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the iterative multiply/accumulate unit.
//   state_t   : sequencer states IDLE / RUN / FIX / DONE
//   OP_*      : accumulate-mode codes carried on op_i (2'b11 behaves as MUL)
//   DEF_*     : default operand width and digit size
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_R     = 2;

endpackage

// File: rtl/mult_acc_step.sv
// ---------------------------------------------------------------------------
// mult_step
// One radix-2^R iteration of the unsigned shift-and-add multiplier, purely
// combinational: acc_o = acc_i + ((mcand_i * digit_i) << shamt_i), mod 2^(2W).
// Ports:
//   mcand_i  [WIDTH-1:0]    unsigned multiplicand magnitude
//   digit_i  [R-1:0]        current multiplier digit
//   shamt_i  [SH_W-1:0]     digit weight (iteration index * R)
//   acc_i    [2*WIDTH-1:0]  running partial product
//   acc_o    [2*WIDTH-1:0]  updated partial product
// ---------------------------------------------------------------------------
module mult_step #(
  parameter int WIDTH = 32,
  parameter int R     = 2,
  parameter int SH_W  = 6
) (
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [R-1:0]       digit_i,
  input  logic [SH_W-1:0]    shamt_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] w_mcand_ext;
  logic [2*WIDTH-1:0] w_term [R];
  logic [2*WIDTH-1:0] w_digit_prod;

  assign w_mcand_ext = {{WIDTH{1'b0}}, mcand_i};

  // One shifted copy of the multiplicand per digit bit that is set.
  for (genvar gi = 0; gi < R; gi++) begin : g_term
    assign w_term[gi] = digit_i[gi] ? (w_mcand_ext << gi) : '0;
  end

  always_comb begin
    w_digit_prod = '0;
    for (int i = 0; i < R; i++) begin
      w_digit_prod = w_digit_prod + w_term[i];
    end
  end

  assign acc_o = acc_i + (w_digit_prod << shamt_i);

endmodule

// File: rtl/mult_acc.sv
// ---------------------------------------------------------------------------
// mult_acc
// Iterative signed/unsigned WIDTH x WIDTH multiplier with optional
// accumulate (hilo + p) or subtract (hilo - p), R multiplier bits per cycle.
// Operands are reduced to magnitudes at accept, multiplied unsigned over
// N = WIDTH/R cycles, then the sign and accumulate step is applied in FIX.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   signed_mult_i         1 = two's-complement operands
//   op_i [1:0]            00 MUL, 01 MADD, 10 MSUB, 11 MUL
//   opdata1_i, opdata2_i  multiplicand, multiplier (sampled at accept)
//   hilo_i [2W-1:0]       accumulator operand (sampled at accept)
//   start_i               request, held until the result is consumed
//   annul_i               abort current operation
//   result_o [2W-1:0]     registered result
//   ready_o               registered result-valid
//   busy_o                high while in RUN or FIX
// ---------------------------------------------------------------------------
module mult_acc
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int R     = DEF_R
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_mult_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int N     = WIDTH / R;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(2 * WIDTH);

  if ((R < 1) || (WIDTH % R != 0)) begin : g_bad_r
    $error("mult_acc: R must be positive and divide WIDTH");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_hilo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_accept;
  logic               w_last_iter;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [SH_W-1:0]    w_shamt;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_final;

  assign w_accept    = start_i && !annul_i;
  assign w_last_iter = (r_cnt == CNT_W'(N - 1));

  // Magnitude of the most-negative value wraps to itself, which is exactly
  // 2^(W-1) when read as unsigned, so W bits are enough.
  assign w_mag1 = (signed_mult_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_mag2 = (signed_mult_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign w_shamt = SH_W'(r_cnt) * SH_W'(R);

  mult_step #(
    .WIDTH (WIDTH),
    .R     (R),
    .SH_W  (SH_W)
  ) u_step (
    .mcand_i (r_mcand),
    .digit_i (r_mplier[R-1:0]),
    .shamt_i (w_shamt),
    .acc_i   (r_acc),
    .acc_o   (w_acc_next)
  );

  assign w_prod = r_neg ? -r_acc : r_acc;

  always_comb begin
    w_final = w_prod;
    case (r_op)
      OP_MADD: w_final = r_hilo + w_prod;
      OP_MSUB: w_final = r_hilo - w_prod;
      default: w_final = w_prod;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = RUN;
      RUN: begin
        if (annul_i)          w_state_next = IDLE;
        else if (w_last_iter) w_state_next = FIX;
      end
      FIX:  w_state_next = annul_i ? IDLE : DONE;
      DONE: if (annul_i || !start_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (r_state == RUN) || (r_state == FIX);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_op     <= OP_MUL;
      r_hilo   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (w_accept) begin
            r_mcand  <= w_mag1;
            r_mplier <= w_mag2;
            r_neg    <= signed_mult_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_op     <= op_i;
            r_hilo   <= hilo_i;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          if (!annul_i) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> R;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          if (annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end else begin
            r_result <= w_final;
            r_ready  <= 1'b1;
          end
        end
        DONE: begin
          if (annul_i || !start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_mult_acc.sv
// ---------------------------------------------------------------------------
// tb_mult_acc
// Directed and random checks of mult_acc against an arithmetic reference
// model (native 64-bit multiply/add/subtract).
// ---------------------------------------------------------------------------
module tb_mult_acc;

  localparam int TB_W = 32;
  localparam int TB_R = 2;
  localparam int LAT  = TB_W / TB_R + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 signed_mult_i;
  logic [1:0]           op_i;
  logic [TB_W-1:0]      opdata1_i;
  logic [TB_W-1:0]      opdata2_i;
  logic [2*TB_W-1:0]    hilo_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*TB_W-1:0]    result_o;
  logic                 ready_o;
  logic                 busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_acc #(.WIDTH(TB_W), .R(TB_R)) dut (
    .clk           (clk),
    .rst           (rst),
    .signed_mult_i (signed_mult_i),
    .op_i          (op_i),
    .opdata1_i     (opdata1_i),
    .opdata2_i     (opdata2_i),
    .hilo_i        (hilo_i),
    .start_i       (start_i),
    .annul_i       (annul_i),
    .result_o      (result_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o)
  );

  function automatic logic [63:0] ref_model(input logic s, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] h);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({32'b0, a}) * longint'({32'b0, b});
    case (op)
      2'b01:   return h + 64'(p);
      2'b10:   return h - 64'(p);
      default: return 64'(p);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Start an operation and scramble the inputs right after accept.
  task automatic launch(input logic s, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h);
    signed_mult_i = s;
    op_i          = op;
    opdata1_i     = a;
    opdata2_i     = b;
    hilo_i        = h;
    start_i       = 1'b1;
    step();
    signed_mult_i = 1'($urandom);
    op_i          = 2'($urandom);
    opdata1_i     = $urandom;
    opdata2_i     = $urandom;
    hilo_i        = {$urandom, $urandom};
  endtask

  task automatic run_op(input string tag, input logic s, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, input int hold);
    logic [63:0] exp;
    int lat;
    exp = ref_model(s, op, a, b, h);
    launch(s, op, a, b, h);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    lat = 0;
    while (!ready_o && lat < LAT + 10) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_busy_done"}, 64'(busy_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold"}, result_o, exp);
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    end
    start_i = 1'b0;
    step();
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
    $display("[TB] %s s=%0d op=%0d a=0x%h b=0x%h hilo=0x%h -> 0x%h lat=%0d",
             tag, s, op, a, b, h, exp, lat);
  endtask

  initial begin
    logic        seen_ready;
    logic        rs;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rh;

    rst           = 1'b1;
    signed_mult_i = 1'b0;
    op_i          = 2'b00;
    opdata1_i     = '0;
    opdata2_i     = '0;
    hilo_i        = '0;
    start_i       = 1'b0;
    annul_i       = 1'b0;
    step();
    step();
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    step();

    // Directed boundary cases
    run_op("umul_max", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0);
    check("umul_max_const", ref_model(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0),
          64'hFFFF_FFFE_0000_0001);
    run_op("smul_minmin", 1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0, 0);
    run_op("smul_neg1x3", 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 64'd0, 0);
    run_op("maddu", 1'b0, 2'b01, 32'd3, 32'd4, 64'd1, 0);
    run_op("msub_s", 1'b1, 2'b10, 32'd2, 32'd3, 64'd0, 0);
    run_op("mul_op3", 1'b1, 2'b11, 32'hFFFF_FFF0, 32'h0000_1234, 64'hDEAD_BEEF_0000_0001, 0);

    // Annul during RUN cycle 5
    launch(1'b0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    for (int i = 0; i < 4; i++) step();
    annul_i = 1'b1;
    step();
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    seen_ready = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (ready_o) seen_ready = 1'b1;
    end
    check("annul_no_result", 64'(seen_ready), 64'd0);
    $display("[TB] annul at RUN cycle 5");
    run_op("after_annul", 1'b0, 2'b00, 32'd7, 32'd6, 64'd0, 0);

    // Hold start in DONE
    run_op("hold3", 1'b1, 2'b01, 32'hFFFF_FF00, 32'h0000_0100, 64'h0000_0001_0000_0000, 3);

    // Start together with annul in IDLE: not accepted
    start_i = 1'b1;
    annul_i = 1'b1;
    step();
    check("start_annul_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    step();
    $display("[TB] start+annul in IDLE");

    // Reset at RUN cycle 8
    launch(1'b1, 2'b01, 32'h8765_4321, 32'h1357_9BDF, 64'h1111_2222_3333_4444);
    for (int i = 0; i < 7; i++) step();
    rst     = 1'b1;
    annul_i = 1'b1;
    step();
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst     = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    step();
    $display("[TB] reset at RUN cycle 8");

    // Random operations
    for (int t = 0; t < 20; t++) begin
      rs  = 1'($urandom);
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      rh  = {$urandom, $urandom};
      if (t % 5 == 0) ra = 32'h8000_0000;
      if (t % 7 == 0) rb = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d", t), rs, rop, ra, rb, rh, t % 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_acc.md
# mult_acc

Parametrised iterative multiply/accumulate unit for the EX stage of the MIPS core. It replaces the fixed 32-bit one-shot multiplier. It computes signed or unsigned WIDTH×WIDTH products R bits per cycle and optionally adds the product to, or subtracts it from, a supplied HI/LO value (MADD/MADDU/MSUB/MSUBU). The start/ready/annul handshake to the pipeline-stall logic is unchanged from the existing multiplier.

## Interface
- WIDTH, 32: operand width; result is 2*WIDTH.
- R, 2: multiplier bits retired per cycle; must divide WIDTH; N = WIDTH/R iterations.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- signed_mult_i  in  1  1 = two's-complement operands.
- op_i  in  2  00 MUL, 01 MADD (hilo_i + p), 10 MSUB (hilo_i − p), 11 treated as MUL.
- opdata1_i, opdata2_i  in  WIDTH  multiplicand, multiplier.
- hilo_i  in  2*WIDTH  accumulator operand (HI:LO), sampled at accept.
- start_i  in  1  request; held high by the pipeline until it consumes ready_o.
- annul_i  in  1  kill current operation (flush/exception).
- result_o  out  2*WIDTH  final value; registered.
- ready_o  out  1  result valid; registered.
- busy_o  out  1  high in RUN and FIX.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: if start_i && !annul_i → latch |op1|, |op2| (magnitudes when signed_mult_i, raw otherwise), neg = signed_mult_i & (op1[W-1]^op2[W-1]), op_i, hilo_i; clear partial product and cnt; → RUN. Otherwise result_o=0, ready_o=0.
- RUN: each cycle add |op1| × (low R bits of multiplier) shifted by cnt*R into the 2W-bit accumulator, shift multiplier right R, cnt++. After the N-th iteration → FIX.
- FIX: p = neg ? −acc : acc (mod 2^(2W)); result_o ← p, hilo+p, or hilo−p per op, all mod 2^(2W); ready_o ← 1; → DONE.
- DONE: hold result_o/ready_o while start_i=1; when start_i=0 → IDLE, clear ready_o and result_o on the same edge.
- annul_i=1 in RUN, FIX or DONE → IDLE on that edge, ready_o=0, result_o=0; no result is ever delivered for an annulled op.
- Width rules: magnitude of the most-negative operand (e.g. 0x8000_0000) is 2^(W-1) and must be held unsigned in W bits. Accumulation wraps silently; no overflow flag.
- start_i high in RUN/FIX is ignored (no re-accept). A new op can be accepted no earlier than the edge after leaving DONE.

## Timing
- Reset: state=IDLE, result_o=0, ready_o=0, busy_o=0, all internal registers cleared.
- Accept at edge E0. Iterations at E1..EN. FIX at E(N+1). ready_o is high after E(N+1). Latency = N+1 cycles; default 17.
- busy_o high from after E0 until after E(N+1).
- Reset asserted mid-operation overrides annul and start: IDLE on that edge, no result.
- Simultaneous start_i=1 and annul_i=1 in IDLE: not accepted.
- Operands and hilo_i may change after accept without effect.

## Structure
- Package mult_pkg: state enum {IDLE, RUN, FIX, DONE}, op codes MUL/MADD/MSUB, default WIDTH/R localparams.
- Sub-module mult_step: combinational one-iteration partial-product add (W-bit magnitude × R-bit digit, shifted, plus 2W-bit accumulator). Instantiated once in mult_acc.
- Elaboration-time check: WIDTH % R == 0.

## Test plan
- Unsigned MUL 0xFFFF_FFFF × 0xFFFF_FFFF → result_o=0xFFFF_FFFE_0000_0001, ready_o rises exactly 17 cycles after accept.
- Signed MUL 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000; signed 0xFFFF_FFFF × 0x0000_0003 → 0xFFFF_FFFF_FFFF_FFFD.
- MADD unsigned, hilo_i=1, 3×4 → 0x0000_0000_0000_000D; MSUB signed, hilo_i=0, 2×3 → 0xFFFF_FFFF_FFFF_FFFA.
- annul_i pulsed at RUN cycle 5 → ready_o never rises and busy_o drops next cycle. A following MUL 7×6 → 0x2A with normal latency.
- Hold start_i 3 extra cycles in DONE → result stable. Drop start_i → ready_o=0, result_o=0 next edge.
- rst asserted at RUN cycle 8 → all outputs 0 next edge. R=1 and R=4 builds give 33- and 9-cycle latency with identical results.
